// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential RV64M divider: widths, FSM states and
// the two's-complement negate used for operand and result sign handling.
package seq_divider_pkg;

   localparam int XLEN      = 64;
   localparam int DIV_ITERS = 64;
   localparam int CNT_W     = 7;

   localparam logic [XLEN-1:0] INT64_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES  = '1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   function automatic logic [XLEN-1:0] neg64(input logic [XLEN-1:0] x);
      return '0 - x;
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and keep the difference when it does not borrow.
module seq_divider_step
   import seq_divider_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic            q_msb_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            take_o
);

   logic [XLEN-1:0] shifted;
   logic [XLEN:0]   diff;

   assign shifted = {rem_i[XLEN-2:0], q_msb_i};
   assign diff    = {1'b0, shifted} - {1'b0, divisor_i};

   // Bit XLEN of diff is the borrow. A bit shifted out of rem makes the true
   // partial remainder exceed any 64-bit divisor, so the subtract always wins.
   assign take_o = rem_i[XLEN-1] | ~diff[XLEN];
   assign rem_o  = take_o ? diff[XLEN-1:0] : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU; busy stalls the pipe
// until a one-cycle done pulse presents quotient, remainder and div_by_zero.
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            div_by_zero
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  dividend_q, divisor_q, dvs_abs_q;
   logic [XLEN-1:0]  qreg_q, rem_q;
   logic             signed_q, q_neg_q, r_neg_q;

   logic             dvd_neg, dvs_neg, is_dbz, is_ovf, take_d;
   logic [XLEN-1:0]  dvd_abs, dvs_abs, rem_d, quotient_d, remainder_d;

   assign dvd_neg = signed_q & dividend_q[XLEN-1];
   assign dvs_neg = signed_q & divisor_q[XLEN-1];
   assign dvd_abs = dvd_neg ? neg64(dividend_q) : dividend_q;
   assign dvs_abs = dvs_neg ? neg64(divisor_q) : divisor_q;

   // Special cases are judged on the raw operands, before any sign fix-up.
   assign is_dbz = (divisor_q == '0);
   assign is_ovf = signed_q && (dividend_q == INT64_MIN) && (divisor_q == ALL_ONES);

   assign quotient_d  = q_neg_q ? neg64(qreg_q) : qreg_q;
   assign remainder_d = r_neg_q ? neg64(rem_q) : rem_q;

   seq_divider_step u_step (
      .rem_i     (rem_q),
      .q_msb_i   (qreg_q[XLEN-1]),
      .divisor_i (dvs_abs_q),
      .rem_o     (rem_d),
      .take_o    (take_d)
   );

   // NOTE: every register here uses <= so all reads see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         dvs_abs_q   <= '0;
         qreg_q      <= '0;
         rem_q       <= '0;
         signed_q    <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dividend_q <= dividend;
                  divisor_q  <= divisor;
                  signed_q   <= is_signed;
                  busy       <= 1'b1;
                  state_q    <= S_PREP;
               end
            end
            S_PREP: begin
               cnt_q     <= '0;
               dvs_abs_q <= dvs_abs;
               if (is_dbz || is_ovf) begin
                  // Load the final answer directly so FIX passes it through unchanged.
                  qreg_q      <= is_dbz ? ALL_ONES : INT64_MIN;
                  rem_q       <= is_dbz ? dividend_q : '0;
                  q_neg_q     <= 1'b0;
                  r_neg_q     <= 1'b0;
                  div_by_zero <= is_dbz;
                  state_q     <= S_FIX;
               end else begin
                  qreg_q      <= dvd_abs;
                  rem_q       <= '0;
                  q_neg_q     <= dvd_neg ^ dvs_neg;
                  r_neg_q     <= dvd_neg;
                  div_by_zero <= 1'b0;
                  state_q     <= S_ITER;
               end
            end
            S_ITER: begin
               rem_q  <= rem_d;
               qreg_q <= {qreg_q[XLEN-2:0], take_d};
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               quotient  <= quotient_d;
               remainder <= remainder_d;
               busy      <= 1'b0;
               done      <= 1'b1;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               done    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
